// File: rtl/whack_scorer_if.sv
`default_nettype none
// ============================================================================
// Module   : whack_scorer_if
// Purpose  : Game-side bundle between the mole generator, buttons and scorer.
// Revision : 1.0 - initial release
// ============================================================================
interface whack_scorer_if #(
  parameter int NUM_HOLES  = 5,
  parameter int POS_W      = 3,
  parameter int SCORE_W    = 4,
  parameter int STREAK_LEN = 3
);
  localparam int STREAK_W = $clog2(STREAK_LEN + 1);

  logic                 key_space;
  logic [POS_W-1:0]     mole_pos;
  logic [NUM_HOLES-1:0] btn;
  logic [SCORE_W-1:0]   score;
  logic [STREAK_W-1:0]  streak;
  logic                 cw;
  logic                 miss;
  logic                 flag_max;
  logic                 flag_low;

  modport master (
    output key_space, mole_pos, btn,
    input  score, streak, cw, miss, flag_max, flag_low
  );

  modport slave (
    input  key_space, mole_pos, btn,
    output score, streak, cw, miss, flag_max, flag_low
  );
endinterface
`default_nettype wire

// File: rtl/whack_scorer.sv
`default_nettype none
// ============================================================================
// Module   : whack_scorer
// Purpose  : Whack-a-mole scorer: one hit per mole, streak bonus, saturating
//            score. Define WHACK_MISS_PENALTY_EN to make misses cost a point.
// Revision : 1.0 - initial release
// ============================================================================
module whack_scorer #(
  parameter int NUM_HOLES  = 5,
  parameter int POS_W      = 3,
  parameter int SCORE_W    = 4,
  parameter int LOW_THRESH = 5,
  parameter int STREAK_LEN = 3
) (
  input  logic          clk,
  input  logic          key_esc,
  whack_scorer_if.slave bus
);
  localparam int                  STREAK_W     = $clog2(STREAK_LEN + 1);
  localparam logic [SCORE_W-1:0]  SMAX         = '1;
  localparam logic [STREAK_W:0]   STREAK_LEN_U = (STREAK_W+1)'(STREAK_LEN);
  localparam logic [31:0]         LOW_THRESH_U = LOW_THRESH;

  logic [NUM_HOLES-1:0] btn_q;
  logic [POS_W-1:0]     pos_q;
  logic                 consumed_q, consumed_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 cw_q, cw_d;
  logic                 miss_q, miss_d;

  logic [NUM_HOLES-1:0] pe;
  logic [NUM_HOLES-1:0] hole_sel;
  logic [NUM_HOLES-1:0] pe_eff;
  logic                 consumed_live;
  logic                 hit;
  logic                 miss_ev;
  logic [STREAK_W:0]    streak_inc;
  logic                 bonus;
  logic [SCORE_W:0]     sum_ext;
`ifdef WHACK_MISS_PENALTY_EN
  logic [SCORE_W:0]     diff_ext;
`endif

  always_comb begin
    pe = bus.btn & ~btn_q;
    hole_sel = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      hole_sel[i] = (bus.mole_pos == POS_W'(i + 1));
    end
    // A mole change this cycle clears consumed before the press is judged.
    consumed_live = consumed_q && (bus.mole_pos == pos_q);
    hit           = (|(pe & hole_sel)) && !consumed_live;
    pe_eff        = consumed_live ? (pe & ~hole_sel) : pe;
    miss_ev       = !hit && (|pe_eff);

    streak_inc = {1'b0, streak_q} + 1'b1;
    bonus      = (streak_inc == STREAK_LEN_U);
    sum_ext    = {1'b0, score_q} + (bonus ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
`ifdef WHACK_MISS_PENALTY_EN
    diff_ext   = {1'b0, score_q} - (SCORE_W+1)'(1);
`endif

    score_d    = score_q;
    streak_d   = streak_q;
    consumed_d = consumed_live;
    cw_d       = 1'b0;
    miss_d     = 1'b0;

    if (!bus.key_space) begin
      if (hit) begin
        consumed_d = 1'b1;
        cw_d       = 1'b1;
        streak_d   = bonus ? '0 : streak_inc[STREAK_W-1:0];
        score_d    = sum_ext[SCORE_W] ? SMAX : sum_ext[SCORE_W-1:0];
      end else if (miss_ev) begin
        miss_d   = 1'b1;
        streak_d = '0;
`ifdef WHACK_MISS_PENALTY_EN
        score_d  = diff_ext[SCORE_W] ? '0 : diff_ext[SCORE_W-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    // Edge history and mole tracking run even in reset and pause.
    btn_q <= bus.btn;
    pos_q <= bus.mole_pos;
    if (key_esc) begin
      score_q    <= '0;
      streak_q   <= '0;
      consumed_q <= 1'b0;
      cw_q       <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      score_q    <= score_d;
      streak_q   <= streak_d;
      consumed_q <= consumed_d;
      cw_q       <= cw_d;
      miss_q     <= miss_d;
    end
  end

  assign bus.score    = score_q;
  assign bus.streak   = streak_q;
  assign bus.cw       = cw_q;
  assign bus.miss     = miss_q;
  assign bus.flag_max = (score_q == SMAX);
  assign bus.flag_low = (32'(score_q) < LOW_THRESH_U);
endmodule
`default_nettype wire
